// File: rtl/uart_tx_feeder.sv
// ---------------------------------------------------------------------------
// uart_tx_feeder
// Byte FIFO in front of a UART transmitter. Producers write bytes at full
// clock rate; the feeder launches them one at a time into the transmitter
// using its data-valid / active / done handshake.
//
// Optional build macro: UART_TX_FEEDER_WATCHDOG_EN
//   When defined, a launch that the transmitter never acknowledges (Active
//   not seen within 4 cycles after o_Tx_DV) is re-pulsed with the same byte.
//
// Ports:
//   i_Clock      system clock, rising edge
//   i_Reset      asynchronous active-high reset
//   i_Wr_DV      write strobe, one byte per cycle
//   i_Wr_Byte    byte to enqueue
//   o_Full       FIFO holds DEPTH bytes
//   o_Empty      FIFO holds 0 bytes
//   o_Count      occupancy 0..DEPTH
//   o_Overflow   sticky: a write was dropped because the FIFO was full
//   o_Tx_DV      one-cycle launch pulse to the transmitter
//   o_Tx_Byte    byte for the transmitter, held until the next load
//   i_Tx_Active  transmitter busy with a frame
//   i_Tx_Done    transmitter frame-complete flag
// ---------------------------------------------------------------------------
module uart_tx_feeder #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              i_Clock,
    input  logic              i_Reset,
    input  logic              i_Wr_DV,
    input  logic [7:0]        i_Wr_Byte,
    output logic              o_Full,
    output logic              o_Empty,
    output logic [ADDR_W:0]   o_Count,
    output logic              o_Overflow,
    output logic              o_Tx_DV,
    output logic [7:0]        o_Tx_Byte,
    input  logic              i_Tx_Active,
    input  logic              i_Tx_Done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_START,
        S_WAIT_END
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_W:0]   count_q, count_d;
    logic              full_q, empty_q, overflow_q;
    logic [7:0]        tx_byte_q;
    logic              wr_en;
    logic              pop;

    // Full is the registered flag, so a write on the same edge as a pop is
    // still rejected when the FIFO was full before that edge.
    assign wr_en = i_Wr_DV && !full_q;

`ifdef UART_TX_FEEDER_WATCHDOG_EN
    // wd_q is 0 in the S_SEND cycle and counts up through S_WAIT_START;
    // reaching 5 means Active was absent for the 4 cycles after o_Tx_DV.
    localparam logic [2:0] WD_LIMIT = 3'd5;
    logic [2:0] wd_q, wd_d;
    logic       wd_expired;

    assign wd_expired = (wd_q == WD_LIMIT);
`endif

    // ------------------------------------------------------------------
    // Launch FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Done still high means the transmitter is in cleanup or the
                // idle cycle right after it; launching then would be lost.
                if (!empty_q && !i_Tx_Active && !i_Tx_Done) begin
                    state_d = S_SEND;
                    pop     = 1'b1;
                end
            end
            S_SEND: begin
                state_d = S_WAIT_START;
            end
            S_WAIT_START: begin
                if (i_Tx_Active) begin
                    state_d = S_WAIT_END;
`ifdef UART_TX_FEEDER_WATCHDOG_EN
                end else if (wd_expired) begin
                    // Re-launch the byte already in tx_byte_q; no new pop.
                    state_d = S_SEND;
`endif
                end
            end
            S_WAIT_END: begin
                if (!i_Tx_Active) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef UART_TX_FEEDER_WATCHDOG_EN
    always_comb begin
        wd_d = wd_q;
        if (state_d == S_SEND) begin
            wd_d = 3'd0;
        end else if (state_q == S_SEND) begin
            wd_d = 3'd1;
        end else if (state_q == S_WAIT_START) begin
            wd_d = wd_q + 3'd1;
        end
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            wd_q <= 3'd0;
        end else begin
            wd_q <= wd_d;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Occupancy
    // ------------------------------------------------------------------
    always_comb begin
        count_d = count_q;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + (ADDR_W+1)'(1);
            2'b01:   count_d = count_q - (ADDR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Control and status registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            tx_byte_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            full_q     <= (count_d == (ADDR_W+1)'(DEPTH));
            empty_q    <= (count_d == '0);
            overflow_q <= overflow_q | (i_Wr_DV & full_q);
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr_q  <= rd_ptr_q + ADDR_W'(1);
                tx_byte_q <= mem_q[rd_ptr_q];
            end
        end
    end

    // Storage has no reset so it maps onto block RAM; reads only happen
    // through the registered tx_byte_q load above. A pop never targets the
    // slot being written: pops need a non-empty FIFO and writes a non-full one.
    always_ff @(posedge i_Clock) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= i_Wr_Byte;
        end
    end

    assign o_Full     = full_q;
    assign o_Empty    = empty_q;
    assign o_Count    = count_q;
    assign o_Overflow = overflow_q;
    assign o_Tx_DV    = (state_q == S_SEND);
    assign o_Tx_Byte  = tx_byte_q;

endmodule
